// File: rtl/router_src_rx.sv
// router_src_rx: source-side packet receiver for the router datapath.
//
// Takes header / payload / parity beats from the source, decodes the destination
// channel from the header and forwards each beat to one of N_CH destination FIFOs.
// The FIFO write is registered, so there is one cycle of latency.
// While the addressed FIFO is full, busy holds the source.
// The block checks even parity (XOR of all beats) on the trailing beat.
// Packets whose address is at or above N_CH are consumed silently and flagged with drop.
//
// Header layout: addr = data_in[ADDR_W-1:0], len = data_in[DATA_W-1:ADDR_W].
// After the header come len payload beats and then one parity beat.
//
// Optional feature (macro ROUTER_SRC_TIMEOUT_EN): the block gives up on a packet
// after TIMEOUT_CYC consecutive idle cycles inside it. It then pulses err and returns to IDLE.
// When the macro is undefined, the block waits indefinitely.
//
// Ports:
//   clk        system clock, rising edge
//   resetn     asynchronous active-low reset
//   pkt_valid  source beat valid
//   data_in    source beat
//   fifo_full  per-channel destination FIFO full
//   busy       backpressure to the source (combinational from state and fifo_full)
//   wr_en      registered one-hot FIFO write enable
//   dout       registered beat data to the FIFOs
//   err        one-cycle pulse: parity mismatch or timeout
//   drop       one-cycle pulse: out-of-range packet fully discarded
//   pkt_done   one-cycle pulse: parity beat written

module router_src_rx #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned N_CH        = 3,
  parameter int unsigned ADDR_W      = 2,
  parameter int unsigned LEN_W       = DATA_W - ADDR_W,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              pkt_valid,
  input  logic [DATA_W-1:0] data_in,
  input  logic [N_CH-1:0]   fifo_full,
  output logic              busy,
  output logic [N_CH-1:0]   wr_en,
  output logic [DATA_W-1:0] dout,
  output logic              err,
  output logic              drop,
  output logic              pkt_done
);

  // Elaboration-time parameter sanity checks.
  if (N_CH < 2 || N_CH > 16) begin : g_bad_n_ch
    $error("router_src_rx: N_CH must be within 2..16");
  end
  if ((1 << ADDR_W) < N_CH) begin : g_bad_addr_w
    $error("router_src_rx: ADDR_W too narrow for N_CH");
  end
  if (LEN_W != DATA_W - ADDR_W) begin : g_bad_len_w
    $error("router_src_rx: LEN_W must equal DATA_W-ADDR_W");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("router_src_rx: TIMEOUT_CYC must be at least 1");
  end

  typedef enum logic [2:0] {
    StIdle,
    StHdrWait,
    StPayload,
    StParity,
    StDrop
  } state_e;

  localparam logic [ADDR_W:0] NChW = (ADDR_W + 1)'(N_CH);

  function automatic logic [N_CH-1:0] ch_onehot(input logic [ADDR_W-1:0] a);
    logic [N_CH-1:0] oh;
    oh = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (a == ADDR_W'(i)) oh[i] = 1'b1;
    end
    return oh;
  endfunction

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   dest_q, dest_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [DATA_W-1:0]   hdr_q, hdr_d;
  logic [N_CH-1:0]     wr_en_q, wr_en_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                err_q, err_d;
  logic                drop_q, drop_d;
  logic                done_q, done_d;

  logic [ADDR_W-1:0]   hdr_addr;
  logic [LEN_W-1:0]    hdr_len;
  logic                hdr_addr_ok;
  logic                in_pkt;
  logic                accept;
  logic                wr_beat;
  logic [DATA_W-1:0]   wr_data;
  logic [ADDR_W-1:0]   wr_dest;

  assign hdr_addr    = data_in[ADDR_W-1:0];
  assign hdr_len     = LEN_W'(data_in[DATA_W-1:ADDR_W]);
  assign hdr_addr_ok = {1'b0, hdr_addr} < NChW;

  // busy only exists while a valid destination has been latched.
  assign in_pkt = (state_q == StHdrWait) || (state_q == StPayload) || (state_q == StParity);
  assign busy   = in_pkt && |(fifo_full & ch_onehot(dest_q));
  assign accept = pkt_valid && !busy;

`ifdef ROUTER_SRC_TIMEOUT_EN
  localparam int unsigned TmoW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TmoW-1:0] tmo_q, tmo_d;
`endif

  always_comb begin
    state_d = state_q;
    dest_d  = dest_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    hdr_d   = hdr_q;
    wr_en_d = '0;
    dout_d  = dout_q;
    err_d   = 1'b0;
    drop_d  = 1'b0;
    done_d  = 1'b0;
    wr_beat = 1'b0;
    wr_data = data_in;
    wr_dest = dest_q;

    unique case (state_q)
      StIdle: begin
        if (pkt_valid) begin
          dest_d = hdr_addr;
          cnt_d  = hdr_len;
          acc_d  = data_in;
          hdr_d  = data_in;
          if (!hdr_addr_ok) begin
            state_d = StDrop;
          end else if (|(fifo_full & ch_onehot(hdr_addr))) begin
            state_d = StHdrWait;
          end else begin
            wr_beat = 1'b1;
            wr_dest = hdr_addr;
            state_d = (hdr_len == '0) ? StParity : StPayload;
          end
        end
      end

      // Header already accepted and latched.
      // Only the deferred write is pending; data_in is not consumed here.
      StHdrWait: begin
        if (!busy) begin
          wr_beat = 1'b1;
          wr_data = hdr_q;
          state_d = (cnt_q == '0) ? StParity : StPayload;
        end
      end

      StPayload: begin
        if (accept) begin
          wr_beat = 1'b1;
          acc_d   = acc_q ^ data_in;
          cnt_d   = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) state_d = StParity;
        end
      end

      StParity: begin
        if (accept) begin
          wr_beat = 1'b1;
          done_d  = 1'b1;
          err_d   = (data_in != acc_q);
          state_d = StIdle;
        end
      end

      // cnt_q holds len; len payload beats plus the parity beat are swallowed.
      StDrop: begin
        if (pkt_valid) begin
          if (cnt_q == '0) begin
            drop_d  = 1'b1;
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q - LEN_W'(1);
          end
        end
      end

      default: state_d = StIdle;
    endcase

`ifdef ROUTER_SRC_TIMEOUT_EN
    // Count only idle cycles the source is free to fill.
    // Stalls under busy do not count, and neither do cycles in HDR_WAIT.
    tmo_d = '0;
    if ((state_q == StPayload) || (state_q == StParity) || (state_q == StDrop)) begin
      if (!pkt_valid && !busy) begin
        if (tmo_q == TmoW'(TIMEOUT_CYC - 1)) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end else if (!accept) begin
        tmo_d = tmo_q;
      end
    end
`endif

    if (wr_beat) begin
      wr_en_d = ch_onehot(wr_dest);
      dout_d  = wr_data;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      dest_q  <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      hdr_q   <= '0;
      wr_en_q <= '0;
      dout_q  <= '0;
      err_q   <= 1'b0;
      drop_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dest_q  <= dest_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      hdr_q   <= hdr_d;
      wr_en_q <= wr_en_d;
      dout_q  <= dout_d;
      err_q   <= err_d;
      drop_q  <= drop_d;
      done_q  <= done_d;
    end
  end

`ifdef ROUTER_SRC_TIMEOUT_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`endif

  assign wr_en    = wr_en_q;
  assign dout     = dout_q;
  assign err      = err_q;
  assign drop     = drop_q;
  assign pkt_done = done_q;

endmodule

// File: tb/tb_router_src_rx.sv
// Directed self-checking bench for router_src_rx at DATA_W=8, N_CH=3, ADDR_W=2.
// Inputs change 1 time unit after the rising edge.
// Registered outputs are checked at that same point, i.e. after the edge that produced them.

module tb_router_src_rx;

  logic       clk;
  logic       resetn;
  logic       pkt_valid;
  logic [7:0] data_in;
  logic [2:0] fifo_full;
  logic       busy;
  logic [2:0] wr_en;
  logic [7:0] dout;
  logic       err;
  logic       drop;
  logic       pkt_done;

  int n_tests = 0;
  int n_fail  = 0;

  router_src_rx #(
    .DATA_W     (8),
    .N_CH       (3),
    .ADDR_W     (2),
    .LEN_W      (6),
    .TIMEOUT_CYC(16)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .pkt_valid(pkt_valid),
    .data_in  (data_in),
    .fifo_full(fifo_full),
    .busy     (busy),
    .wr_en    (wr_en),
    .dout     (dout),
    .err      (err),
    .drop     (drop),
    .pkt_done (pkt_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn    = 1'b0;
    pkt_valid = 1'b0;
    data_in   = 8'h00;
    fifo_full = 3'b000;
    tick();
    tick();
    n_tests++;
    if (wr_en !== 3'b000 || dout !== 8'h00 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_data: wr_en=%b dout=%h busy=%b, expected 000/00/0", wr_en, dout, busy);
    end
    n_tests++;
    if (err !== 1'b0 || drop !== 1'b0 || pkt_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: err=%b drop=%b pkt_done=%b, expected 0/0/0", err, drop, pkt_done);
    end
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_good();
    logic [7:0] beats [5] = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
    for (int i = 0; i < 5; i++) begin
      pkt_valid = 1'b1;
      data_in   = beats[i];
      tick();
      n_tests++;
      if (wr_en !== 3'b010 || dout !== beats[i]) begin
        n_fail++;
        $display("FAIL good_write[%0d]: wr_en=%b dout=%h, expected 010/%h", i, wr_en, dout, beats[i]);
      end
      n_tests++;
      if (pkt_done !== (i == 4) || err !== 1'b0) begin
        n_fail++;
        $display("FAIL good_flags[%0d]: pkt_done=%b err=%b, expected %b/0", i, pkt_done, err, (i == 4));
      end
    end
    pkt_valid = 1'b0;
    tick();
    n_tests++;
    if (wr_en !== 3'b000 || pkt_done !== 1'b0 || dout !== 8'h0D) begin
      n_fail++;
      $display("FAIL good_after: wr_en=%b pkt_done=%b dout=%h, expected 000/0/0d", wr_en, pkt_done, dout);
    end
  endtask

  task automatic test_bad_parity();
    logic [7:0] beats [5] = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0E};
    for (int i = 0; i < 5; i++) begin
      pkt_valid = 1'b1;
      data_in   = beats[i];
      tick();
      n_tests++;
      if (wr_en !== 3'b010 || dout !== beats[i]) begin
        n_fail++;
        $display("FAIL badpar_write[%0d]: wr_en=%b dout=%h, expected 010/%h", i, wr_en, dout, beats[i]);
      end
      n_tests++;
      if (err !== (i == 4) || pkt_done !== (i == 4)) begin
        n_fail++;
        $display("FAIL badpar_flags[%0d]: err=%b pkt_done=%b, expected %b/%b", i, err, pkt_done,
                 (i == 4), (i == 4));
      end
    end
    pkt_valid = 1'b0;
    tick();
    n_tests++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL badpar_err_pulse: err=%b, expected 0", err);
    end
  endtask

  task automatic test_invalid_addr();
    logic [7:0] beats [3] = '{8'h07, 8'hAA, 8'hAD};
    for (int i = 0; i < 3; i++) begin
      pkt_valid = 1'b1;
      data_in   = beats[i];
      #1;
      n_tests++;
      if (busy !== 1'b0) begin
        n_fail++;
        $display("FAIL drop_busy[%0d]: busy=%b, expected 0", i, busy);
      end
      tick();
      n_tests++;
      if (wr_en !== 3'b000 || drop !== (i == 2)) begin
        n_fail++;
        $display("FAIL drop_beat[%0d]: wr_en=%b drop=%b, expected 000/%b", i, wr_en, drop, (i == 2));
      end
    end
    pkt_valid = 1'b0;
    tick();
    n_tests++;
    if (drop !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_pulse: drop=%b err=%b, expected 0/0", drop, err);
    end
  endtask

  // Packet A: ch0, len0. Packet B: ch2, len1, parity 06^5A=5C. No gap between them.
  task automatic test_back_to_back();
    logic [7:0] beats [5] = '{8'h00, 8'h00, 8'h06, 8'h5A, 8'h5C};
    logic [2:0] chans [5] = '{3'b001, 3'b001, 3'b100, 3'b100, 3'b100};
    logic       dones [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      pkt_valid = 1'b1;
      data_in   = beats[i];
      tick();
      n_tests++;
      if (wr_en !== chans[i] || dout !== beats[i] || pkt_done !== dones[i] || err !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b[%0d]: wr_en=%b dout=%h done=%b err=%b, expected %b/%h/%b/0", i, wr_en,
                 dout, pkt_done, err, chans[i], beats[i], dones[i]);
      end
    end
    pkt_valid = 1'b0;
    tick();
  endtask

  // Header 0x0A: ch2, len2. Payload 3C, C3, parity 0A^3C^C3 = F5.
  task automatic test_fifo_full();
    fifo_full = 3'b100;
    pkt_valid = 1'b1;
    data_in   = 8'h0A;
    tick();
    n_tests++;
    if (wr_en !== 3'b000) begin
      n_fail++;
      $display("FAIL full_hdr_nowrite: wr_en=%b, expected 000", wr_en);
    end
    pkt_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (busy !== 1'b1) begin
        n_fail++;
        $display("FAIL full_busy[%0d]: busy=%b, expected 1", i, busy);
      end
      tick();
      n_tests++;
      if (wr_en !== 3'b000) begin
        n_fail++;
        $display("FAIL full_hold[%0d]: wr_en=%b, expected 000", i, wr_en);
      end
    end
    fifo_full = 3'b000;
    tick();
    n_tests++;
    if (wr_en !== 3'b100 || dout !== 8'h0A) begin
      n_fail++;
      $display("FAIL full_hdr_write: wr_en=%b dout=%h, expected 100/0a", wr_en, dout);
    end
    // Other channels full must not stall a ch2 packet.
    fifo_full = 3'b011;
    pkt_valid = 1'b1;
    data_in   = 8'h3C;
    #1;
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL full_other_ch_busy: busy=%b, expected 0", busy);
    end
    tick();
    n_tests++;
    if (wr_en !== 3'b100 || dout !== 8'h3C) begin
      n_fail++;
      $display("FAIL full_p1: wr_en=%b dout=%h, expected 100/3c", wr_en, dout);
    end
    // fifo_full rises together with the next beat: not accepted.
    fifo_full = 3'b100;
    data_in   = 8'hC3;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_tests++;
      if (busy !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_busy[%0d]: busy=%b, expected 1", i, busy);
      end
      tick();
      n_tests++;
      if (wr_en !== 3'b000 || dout !== 8'h3C) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: wr_en=%b dout=%h, expected 000/3c", i, wr_en, dout);
      end
    end
    fifo_full = 3'b000;
    tick();
    n_tests++;
    if (wr_en !== 3'b100 || dout !== 8'hC3) begin
      n_fail++;
      $display("FAIL full_p2: wr_en=%b dout=%h, expected 100/c3", wr_en, dout);
    end
    data_in = 8'hF5;
    tick();
    n_tests++;
    if (wr_en !== 3'b100 || dout !== 8'hF5 || pkt_done !== 1'b1 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL full_parity: wr_en=%b dout=%h done=%b err=%b, expected 100/f5/1/0", wr_en,
               dout, pkt_done, err);
    end
    pkt_valid = 1'b0;
    tick();
  endtask

  // Sends 04, 55, 51 to ch0 and checks each write.
  task automatic test_ch0_packet(input string tag);
    logic [7:0] beats [3] = '{8'h04, 8'h55, 8'h51};
    for (int i = 0; i < 3; i++) begin
      pkt_valid = 1'b1;
      data_in   = beats[i];
      tick();
      n_tests++;
      if (wr_en !== 3'b001 || dout !== beats[i] || pkt_done !== (i == 2) || err !== 1'b0) begin
        n_fail++;
        $display("FAIL %s[%0d]: wr_en=%b dout=%h done=%b err=%b, expected 001/%h/%b/0", tag, i,
                 wr_en, dout, pkt_done, err, beats[i], (i == 2));
      end
    end
    pkt_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    pkt_valid = 1'b1;
    data_in   = 8'h0D;
    tick();
    data_in   = 8'h11;
    tick();
    data_in   = 8'h22;
    fifo_full = 3'b010;
    resetn    = 1'b0;
    #1;
    n_tests++;
    if (wr_en !== 3'b000 || dout !== 8'h00 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_async: wr_en=%b dout=%h busy=%b, expected 000/00/0", wr_en, dout, busy);
    end
    tick();
    n_tests++;
    if (wr_en !== 3'b000 || err !== 1'b0 || drop !== 1'b0 || pkt_done !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_held: wr_en=%b err=%b drop=%b done=%b, expected 000/0/0/0", wr_en,
               err, drop, pkt_done);
    end
    pkt_valid = 1'b0;
    fifo_full = 3'b000;
    resetn    = 1'b1;
    tick();
    test_ch0_packet("rstmid_pkt");
  endtask

  task automatic test_idle_gap();
`ifdef ROUTER_SRC_TIMEOUT_EN
    pkt_valid = 1'b1;
    data_in   = 8'h0D;
    tick();
    pkt_valid = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      n_tests++;
      if (err !== (i == 16) || wr_en !== 3'b000) begin
        n_fail++;
        $display("FAIL timeout[%0d]: err=%b wr_en=%b, expected %b/000", i, err, wr_en, (i == 16));
      end
    end
    tick();
    n_tests++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_pulse: err=%b, expected 0", err);
    end
    test_ch0_packet("timeout_next");
`else
    logic [7:0] rest [4] = '{8'h11, 8'h22, 8'h33, 8'h0D};
    pkt_valid = 1'b1;
    data_in   = 8'h0D;
    tick();
    pkt_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_tests++;
      if (wr_en !== 3'b000 || err !== 1'b0) begin
        n_fail++;
        $display("FAIL gap_wait[%0d]: wr_en=%b err=%b, expected 000/0", i, wr_en, err);
      end
    end
    for (int i = 0; i < 4; i++) begin
      pkt_valid = 1'b1;
      data_in   = rest[i];
      tick();
      n_tests++;
      if (wr_en !== 3'b010 || dout !== rest[i] || pkt_done !== (i == 3) || err !== 1'b0) begin
        n_fail++;
        $display("FAIL gap_resume[%0d]: wr_en=%b dout=%h done=%b err=%b, expected 010/%h/%b/0", i,
                 wr_en, dout, pkt_done, err, rest[i], (i == 3));
      end
    end
    pkt_valid = 1'b0;
    tick();
`endif
  endtask

  initial begin
    test_reset();
    test_good();
    test_bad_parity();
    test_invalid_addr();
    test_back_to_back();
    test_fifo_full();
    test_reset_mid();
    test_idle_gap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/router_src_rx.md
Name: router_src_rx

Overview:
- Parametrised source-side packet receiver for the router datapath, the successor to the fixed 8-bit, 3-port source stage.
- Accepts header/payload/parity beats from the source interface and decodes the destination address.
- Steers every beat to one of N_CH destination FIFOs with per-channel write enables.
- Applies busy backpressure while the addressed FIFO is full, checks packet parity, and discards packets whose address is out of range.

Parameters:
- DATA_W, 8, beat width in bits.
- N_CH, 3, number of destination channels (2..16).
- ADDR_W, 2, header address field width; must satisfy 2**ADDR_W >= N_CH.
- LEN_W, DATA_W-ADDR_W, payload length field width, taken from header bits [DATA_W-1:ADDR_W].
- TIMEOUT_CYC, 16, idle-cycle limit inside a packet (used only with the optional feature).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- resetn  in  1  asynchronous active-low reset.
- pkt_valid  in  1  source beat valid.
- data_in  in  DATA_W  source beat.
- fifo_full  in  N_CH  per-channel destination FIFO full.
- busy  out  1  backpressure; the source holds data_in/pkt_valid while busy=1.
- wr_en  out  N_CH  one-hot registered FIFO write enable.
- dout  out  DATA_W  registered beat data to the FIFOs.
- err  out  1  one-cycle pulse on a parity mismatch or timeout.
- drop  out  1  one-cycle pulse when an out-of-range packet finishes being discarded.
- pkt_done  out  1  one-cycle pulse when a parity beat is written.

Behaviour:
- Reset (async, resetn=0): state=IDLE; wr_en=0, dout=0, err=0, drop=0, pkt_done=0, busy=0; length counter, parity accumulator and dest register cleared.
- Packet framing:
  - Beat 0 is the header: addr = data_in[ADDR_W-1:0], len = data_in[DATA_W-1:ADDR_W].
  - Then exactly len payload beats, then one parity beat. All beats carry pkt_valid=1.
  - A beat is accepted when pkt_valid=1 and busy=0.
- busy is combinational from registered state and fifo_full: busy = (state in {HDR_WAIT, PAYLOAD, PARITY}) && fifo_full[dest]. busy=0 in IDLE and DROP.
- Accepted beat at edge k produces wr_en[dest]=1 and dout=beat at edge k+1 (1-cycle latency). Otherwise wr_en=0 and dout holds its value.
- FSM:
  - IDLE, pkt_valid=1: latch dest=addr, cnt=len, acc=data_in.
    - addr>=N_CH -> DROP.
    - Else fifo_full[addr]=1 -> HDR_WAIT (header held, nothing written).
    - Else write the header, then PAYLOAD if len>0, or PARITY if len=0.
  - HDR_WAIT: once fifo_full[dest]=0, write the latched header, then PAYLOAD or PARITY as above.
  - PAYLOAD: on accept, write the beat, acc^=data_in, cnt-=1. When cnt reaches 1 on that accept -> PARITY.
  - PARITY: on accept, write the beat, pulse pkt_done. Pulse err if data_in != acc. Then IDLE.
  - DROP: consume len+1 further beats with busy=0 and no writes. Pulse drop on the last one, then IDLE.
- pkt_valid=0 mid-packet: wait indefinitely. No state change, no writes.
- Simultaneous events: fifo_full rising on the same edge a beat arrives means busy=1 that cycle and the beat is not accepted.
- A new header is recognised only in IDLE. Back-to-back packets are allowed with zero idle cycles.
- Maximum length 2**LEN_W-1 (63 at defaults); the counter never wraps.
- Reset asserted mid-packet: immediate return to IDLE. The partial packet is abandoned with no further writes; no err, drop or pkt_done pulse.

Optional Feature:
- Macro ROUTER_SRC_TIMEOUT_EN.
- Defined:
  - An idle counter counts consecutive cycles with pkt_valid=0 in PAYLOAD, PARITY or DROP, reset on each accepted beat.
  - At TIMEOUT_CYC the block pulses err, returns to IDLE and writes nothing further.
  - Cycles in HDR_WAIT, and cycles where busy=1, are not counted.
- Undefined: no counter logic; the block waits indefinitely.

Test Plan (DATA_W=8, N_CH=3, ADDR_W=2):
- Good packet: header 0x0D (addr1, len3), payload 0x11,0x22,0x33, parity 0x0D, no stalls -> wr_en=3'b010 for 5 consecutive cycles with dout 0x0D,0x11,0x22,0x33,0x0D; pkt_done pulses with the last write; err=0.
- Bad parity: same packet with parity 0x0E -> 5 writes to ch1; err and pkt_done pulse together on the 5th write.
- Invalid address: header 0x07 (addr3, len1), then 0xAA and 0xAD -> busy=0 throughout, wr_en=0 throughout, drop pulses once after the 3rd beat.
- FIFO full: fifo_full=3'b100 before header 0x0A (addr2, len2) -> busy=1 and no writes; release after 4 cycles -> header written next edge, then 2 payload beats and parity to ch2; mid-payload fifo_full[2]=1 for 2 cycles stalls with data held.
- Reset mid-packet: resetn=0 after header 0x0D plus 1 payload beat -> all outputs 0 asynchronously; after release, packet 0x04 (addr0, len1), 0x55, parity 0x51 completes normally on ch0.
- With ROUTER_SRC_TIMEOUT_EN and TIMEOUT_CYC=16: header 0x0D, then pkt_valid=0 for 16 cycles -> err pulses, return to IDLE; next header accepted normally.
